// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg_pkg : shared types for the inter-stage pipeline register
// Rev 1.0
// ============================================================================
package pipe_stage_reg_pkg;

    // Encoding equals the number of held entries, so occ can be read straight off it.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_BUSY  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_entry.sv
`default_nettype none
// ============================================================================
// pipe_entry : one valid + ctrl + data register; ctrl is cleared with valid
// Rev 1.0
// ============================================================================
module pipe_entry
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int CTRL_W     = 12,
    parameter int RESET_DATA = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              drop,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // drop wins over load so a flush never lets a new entry in.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (drop) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= load_ctrl;
        end
    end

    generate
        if (RESET_DATA != 0) begin : g_data_rst
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    data <= '0;
                end else if (load && !drop) begin
                    data <= load_data;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                if (load && !drop) begin
                    data <= load_data;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg : valid/ready pipeline register with flush and optional skid
// Rev 1.0
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int CTRL_W     = 12,
    parameter int SKID       = 1,
    parameter int RESET_DATA = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              main_drop;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data_in;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    pipe_entry #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .RESET_DATA (RESET_DATA)
    ) u_main (
        .clk       (clk),
        .resetn    (resetn),
        .load      (main_load),
        .drop      (main_drop),
        .load_ctrl (main_ctrl_in),
        .load_data (main_data_in),
        .valid     (out_valid),
        .ctrl      (out_ctrl),
        .data      (out_data)
    );

    generate
        if (SKID == 0) begin : g_single
            assign in_ready     = ~out_valid | out_ready;
            assign main_load    = in_fire & ~flush;
            assign main_drop    = flush | (out_fire & ~in_fire);
            assign main_ctrl_in = in_ctrl;
            assign main_data_in = in_data;
            assign occ          = {1'b0, out_valid};
        end else begin : g_skid
            occ_state_t        state;
            occ_state_t        state_next;
            logic              ready_q;
            logic              skid_load;
            logic              skid_drop;
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            pipe_entry #(
                .DATA_W     (DATA_W),
                .CTRL_W     (CTRL_W),
                .RESET_DATA (RESET_DATA)
            ) u_skid (
                .clk       (clk),
                .resetn    (resetn),
                .load      (skid_load),
                .drop      (skid_drop),
                .load_ctrl (in_ctrl),
                .load_data (in_data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    state   <= OCC_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state   <= state_next;
                    ready_q <= (state_next != OCC_FULL);
                end
            end

            // in_fire cannot occur in FULL because ready_q is low there.
            always_comb begin
                state_next   = state;
                main_load    = 1'b0;
                main_drop    = 1'b0;
                skid_load    = 1'b0;
                skid_drop    = 1'b0;
                main_ctrl_in = in_ctrl;
                main_data_in = in_data;
                if (flush) begin
                    state_next = OCC_EMPTY;
                    main_drop  = 1'b1;
                    skid_drop  = 1'b1;
                end else begin
                    case (state)
                        OCC_EMPTY: begin
                            if (in_fire) begin
                                main_load  = 1'b1;
                                state_next = OCC_BUSY;
                            end
                        end
                        OCC_BUSY: begin
                            if (in_fire && out_fire) begin
                                main_load = 1'b1;
                            end else if (in_fire) begin
                                skid_load  = 1'b1;
                                state_next = OCC_FULL;
                            end else if (out_fire) begin
                                main_drop  = 1'b1;
                                state_next = OCC_EMPTY;
                            end
                        end
                        OCC_FULL: begin
                            if (out_fire) begin
                                main_load    = 1'b1;
                                main_ctrl_in = skid_ctrl;
                                main_data_in = skid_data;
                                skid_drop    = 1'b1;
                                state_next   = OCC_BUSY;
                            end
                        end
                        default: begin
                            state_next = OCC_EMPTY;
                            main_drop  = 1'b1;
                            skid_drop  = 1'b1;
                        end
                    endcase
                end
            end

            assign in_ready = ready_q;
            assign occ      = {1'b0, out_valid} + {1'b0, skid_valid};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_reg : checks SKID=0 and SKID=1 stages against a queue model
// Rev 1.0
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW = 256;
    localparam int CW = 12;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          rdy [2];
    logic          ov  [2];
    logic [CW-1:0] oc  [2];
    logic [DW-1:0] od  [2];
    logic [1:0]    oo  [2];

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .RESET_DATA(0)) dut0 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]), .out_data(od[0]),
        .occ(oo[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .RESET_DATA(1)) dut1 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]), .out_data(od[1]),
        .occ(oo[1])
    );

    int         vectors = 0;
    int         miscompares = 0;
    ent_t       q [2][$];
    logic [DW-1:0] last_d [2];
    bit         have_d [2];
    bit         exp_rdy [2];
    bit         stall;

    task automatic chk(input string tag, input int k, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[skid=%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Inputs are set by the caller; compare, then advance the model at the edge.
    task automatic cycle();
        #1;
        stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bit exp_v;
            exp_v      = q[k].size() > 0;
            exp_rdy[k] = (k == 1) ? (q[k].size() < 2) : (q[k].size() == 0 || out_ready);
            chk("out_valid", k, DW'(ov[k]), DW'(exp_v));
            chk("in_ready",  k, DW'(rdy[k]), DW'(exp_rdy[k]));
            chk("occ",       k, DW'(oo[k]), DW'(q[k].size()));
            chk("out_ctrl",  k, DW'(oc[k]), exp_v ? DW'(q[k][0].c) : '0);
            if (exp_v) begin
                last_d[k] = q[k][0].d;
                have_d[k] = 1'b1;
            end
            if (have_d[k]) chk("out_data", k, od[k], last_d[k]);
            chk("occ_bound", k, DW'(oo[k] <= 2'(1 + k)), DW'(1));
            chk("ctrl_implies_valid", k, DW'((oc[k] == '0) || ov[k]), DW'(1));
            if (in_valid && !exp_rdy[k]) stall = 1'b1;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                q[k].delete();
                if (k == 1) begin
                    last_d[k] = '0;
                    have_d[k] = 1'b1;
                end
            end else if (flush) begin
                q[k].delete();
            end else begin
                bit of;
                of = (q[k].size() > 0) && out_ready;
                if (of) void'(q[k].pop_front());
                if (in_valid && exp_rdy[k]) q[k].push_back('{c: in_ctrl, d: in_data});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rd);
        in_valid  = 1'b0;
        out_ready = rd;
        flush     = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        have_d[0] = 1'b0;
        have_d[1] = 1'b1;
        last_d[0] = '0;
        last_d[1] = '0;

        // Reset held two cycles with a valid, all-ones entry presented.
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = '1;
        in_data   = '1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cycle();
        resetn = 1'b1;
        in_valid = 1'b0;
        cycle();

        // Streaming at one entry per cycle.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CW'(i);
            in_data  = DW'(i * 32'h1111);
            cycle();
        end
        idle(3, 1'b1);

        // Backpressure: A then B with out_ready low.
        in_valid = 1'b1; in_ctrl = 12'h0A0; in_data = DW'(32'hAAAA); out_ready = 1'b0;
        cycle();
        in_ctrl = 12'h0B0; in_data = DW'(32'hBBBB);
        cycle();
        in_valid = 1'b0;
        #1;
        chk("bp_occ_full", 1, DW'(oo[1]), DW'(2));
        chk("bp_ready_low", 1, DW'(rdy[1]), DW'(0));
        chk("bp_head_A", 1, DW'(oc[1]), DW'(12'h0A0));
        cycle();
        idle(4, 1'b1);

        // Bubble: ctrl cleared, data held.
        in_valid = 1'b1; in_ctrl = 12'hFFF; in_data = DW'(32'hDEAD); out_ready = 1'b1;
        cycle();
        idle(2, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("bubble_data", k, od[k], DW'(32'hDEAD));
            chk("bubble_ctrl", k, DW'(oc[k]), '0);
        end

        // Flush while FULL with an incoming entry in the same cycle.
        in_valid = 1'b1; in_ctrl = 12'h111; in_data = DW'(32'h1); out_ready = 1'b0;
        cycle();
        in_ctrl = 12'h222; in_data = DW'(32'h2);
        cycle();
        in_ctrl = 12'h333; in_data = DW'(32'h3); out_ready = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_occ", 1, DW'(oo[1]), DW'(0));
        chk("flush_valid", 0, DW'(ov[0]), DW'(0));
        cycle();
        idle(3, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 10000; n++) begin
            if (!stall) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_ctrl  = CW'($urandom);
                in_data  = {8{$urandom}};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cycle();
        end
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
